// File: rtl/ahb_slave_trace_buf.sv
// Circular transaction trace buffer tapping the AHB slave memory port, with address trigger and indexed readout.
// Optional AHB_TRACE_TIMESTAMP_EN appends a 16-bit free-running cycle stamp to every entry.
module ahb_slave_trace_buf #(
    parameter int ADDR_BITS  = 24,
    parameter int DATA_BITS  = 32,
    parameter int DEPTH_LOG2 = 6,
    parameter int SLAVE_NUM  = 0,
`ifdef AHB_TRACE_TIMESTAMP_EN
    localparam int TS_BITS   = 16,
`else
    localparam int TS_BITS   = 0,
`endif
    localparam int ENTRY_BITS = 1 + DATA_BITS/8 + ADDR_BITS + DATA_BITS + TS_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    WR,
    input  logic [ADDR_BITS-1:0]    ADDR_WR,
    input  logic [DATA_BITS-1:0]    DIN,
    input  logic [DATA_BITS/8-1:0]  BSEL,
    input  logic                    RD,
    input  logic [ADDR_BITS-1:0]    ADDR_RD,
    input  logic [DATA_BITS-1:0]    DOUT,
    input  logic                    arm,
    input  logic                    stop,
    input  logic                    force_trig,
    input  logic [ADDR_BITS-1:0]    trig_addr,
    input  logic [ADDR_BITS-1:0]    trig_mask,
    input  logic                    trig_wr,
    input  logic                    trig_rd,
    input  logic [DEPTH_LOG2-1:0]   post_len,
    input  logic [DEPTH_LOG2-1:0]   rd_idx,
    output logic [ENTRY_BITS-1:0]   rd_data,
    output logic [1:0]              state,
    output logic [DEPTH_LOG2:0]     entry_cnt,
    output logic [7:0]              drop_cnt,
    output logic [7:0]              slave_id
);

    localparam int BSEL_BITS = DATA_BITS / 8;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_POST  = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t cur_state, next_state;

    logic                    rd_d;
    logic [ADDR_BITS-1:0]    rd_addr_d;
    logic                    rdp_valid;
    logic [ENTRY_BITS-1:0]   rdp_entry;
    logic                    hold_valid;
    logic [ENTRY_BITS-1:0]   hold_entry;
    logic [DEPTH_LOG2-1:0]   wptr;
    logic [DEPTH_LOG2-1:0]   post_cnt;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [ENTRY_BITS-1:0]   wr_entry;
    logic [ENTRY_BITS-1:0]   rd_entry;
    logic [ENTRY_BITS-1:0]   mem [0:(1<<DEPTH_LOG2)-1];

    logic                    ram_we;
    logic [ENTRY_BITS-1:0]   ram_wdata;
    logic                    hold_load;
    logic                    hold_clear;
    logic                    drop;
    logic                    trig;
    logic                    post_load;
    logic                    post_dec;
    logic                    rec_type;
    logic [ADDR_BITS-1:0]    rec_addr;

`ifdef AHB_TRACE_TIMESTAMP_EN
    logic [15:0] ts_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_cnt <= 16'd0;
        else       ts_cnt <= ts_cnt + 16'd1;
    end

    assign wr_entry = {1'b1, BSEL, ADDR_WR, DIN, ts_cnt};
    assign rd_entry = {1'b0, {BSEL_BITS{1'b1}}, rd_addr_d, DOUT, ts_cnt};
`else
    assign wr_entry = {1'b1, BSEL, ADDR_WR, DIN};
    assign rd_entry = {1'b0, {BSEL_BITS{1'b1}}, rd_addr_d, DOUT};
`endif

    // Read path: RD/ADDR_RD registered, entry formed with DOUT next cycle, then staged for arbitration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_d      <= 1'b0;
            rd_addr_d <= '0;
            rdp_valid <= 1'b0;
            rdp_entry <= '0;
        end else begin
            rd_d      <= RD;
            rd_addr_d <= ADDR_RD;
            rdp_valid <= rd_d;
            rdp_entry <= rd_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur_state <= S_IDLE;
        else       cur_state <= next_state;
    end

    always_comb begin
        next_state = cur_state;
        ram_we     = 1'b0;
        ram_wdata  = wr_entry;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        drop       = 1'b0;
        trig       = 1'b0;
        post_load  = 1'b0;
        post_dec   = 1'b0;
        rec_type   = 1'b0;
        rec_addr   = '0;
        if (arm) begin
            next_state = S_ARMED;
            hold_clear = 1'b1;
        end else if (stop && (cur_state == S_ARMED || cur_state == S_POST)) begin
            next_state = S_DONE;
            hold_clear = 1'b1;
        end else if (cur_state == S_ARMED || cur_state == S_POST) begin
            if (WR) begin
                ram_we    = 1'b1;
                ram_wdata = wr_entry;
            end else if (hold_valid) begin
                ram_we     = 1'b1;
                ram_wdata  = hold_entry;
                hold_clear = 1'b1;
            end else if (rdp_valid) begin
                ram_we    = 1'b1;
                ram_wdata = rdp_entry;
            end
            // A losing read can take the hold slot only if it is empty or draining this cycle.
            if (rdp_valid && (WR || hold_valid)) begin
                if (!hold_valid || !WR) hold_load = 1'b1;
                else                    drop      = 1'b1;
            end
            rec_type = ram_wdata[ENTRY_BITS-1];
            rec_addr = ram_wdata[TS_BITS+DATA_BITS +: ADDR_BITS];
            trig = force_trig ||
                   (ram_we && (rec_type ? trig_wr : trig_rd) &&
                    ((rec_addr & trig_mask) == (trig_addr & trig_mask)));
            if (cur_state == S_ARMED && trig) begin
                if (post_len == '0) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_POST;
                    post_load  = 1'b1;
                end
            end else if (cur_state == S_POST && ram_we) begin
                post_dec = 1'b1;
                if (post_cnt == PTR_ONE) next_state = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_entry <= '0;
        end else if (hold_load) begin
            hold_valid <= 1'b1;
            hold_entry <= rdp_entry;
        end else if (hold_clear) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            entry_cnt <= '0;
            drop_cnt  <= 8'd0;
            post_cnt  <= '0;
        end else if (arm) begin
            wptr      <= '0;
            entry_cnt <= '0;
            drop_cnt  <= 8'd0;
        end else begin
            if (ram_we) begin
                wptr <= wptr + PTR_ONE;
                if (!entry_cnt[DEPTH_LOG2]) entry_cnt <= entry_cnt + CNT_ONE;
            end
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            if (post_load)     post_cnt <= post_len;
            else if (post_dec) post_cnt <= post_cnt - PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[wptr] <= ram_wdata;
    end

    // Once full the write pointer marks the oldest entry.
    assign rd_ptr = (entry_cnt[DEPTH_LOG2] ? wptr : '0) + rd_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_data <= '0;
        else       rd_data <= mem[rd_ptr];
    end

    assign state    = cur_state;
    assign slave_id = 8'(SLAVE_NUM);

endmodule

// File: tb/tb_ahb_slave_trace_buf.sv
// Directed self-checking bench for ahb_slave_trace_buf: capture, read latency, wrap, trigger, collisions, reset.
module tb_ahb_slave_trace_buf;

    localparam int AB = 24;
    localparam int DB = 32;
    localparam int DL = 6;
    localparam int BASE_W = 1 + DB/8 + AB + DB;
`ifdef AHB_TRACE_TIMESTAMP_EN
    localparam int TS_W = 16;
`else
    localparam int TS_W = 0;
`endif
    localparam int ENTRY_W = BASE_W + TS_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              WR = 1'b0;
    logic [AB-1:0]     ADDR_WR = '0;
    logic [DB-1:0]     DIN = '0;
    logic [DB/8-1:0]   BSEL = '0;
    logic              RD = 1'b0;
    logic [AB-1:0]     ADDR_RD = '0;
    logic [DB-1:0]     DOUT = '0;
    logic              arm = 1'b0;
    logic              stop = 1'b0;
    logic              force_trig = 1'b0;
    logic [AB-1:0]     trig_addr = '0;
    logic [AB-1:0]     trig_mask = '0;
    logic              trig_wr = 1'b0;
    logic              trig_rd = 1'b0;
    logic [DL-1:0]     post_len = '0;
    logic [DL-1:0]     rd_idx = '0;
    logic [ENTRY_W-1:0] rd_data;
    logic [1:0]        state;
    logic [DL:0]       entry_cnt;
    logic [7:0]        drop_cnt;
    logic [7:0]        slave_id;

    int vectors = 0;
    int miscompares = 0;

    ahb_slave_trace_buf #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .DEPTH_LOG2(DL), .SLAVE_NUM(5)
    ) dut (
        .clk(clk), .reset(reset),
        .WR(WR), .ADDR_WR(ADDR_WR), .DIN(DIN), .BSEL(BSEL),
        .RD(RD), .ADDR_RD(ADDR_RD), .DOUT(DOUT),
        .arm(arm), .stop(stop), .force_trig(force_trig),
        .trig_addr(trig_addr), .trig_mask(trig_mask),
        .trig_wr(trig_wr), .trig_rd(trig_rd), .post_len(post_len),
        .rd_idx(rd_idx), .rd_data(rd_data), .state(state),
        .entry_cnt(entry_cnt), .drop_cnt(drop_cnt), .slave_id(slave_id)
    );

    always #5 clk = ~clk;

    function automatic logic [BASE_W-1:0] make_entry(input logic typ, input logic [3:0] bs,
                                                     input logic [AB-1:0] a, input logic [DB-1:0] d);
        return {typ, bs, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_write(input logic [AB-1:0] a, input logic [DB-1:0] d, input logic [3:0] bs);
        WR = 1'b1; ADDR_WR = a; DIN = d; BSEL = bs;
        tick();
        WR = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic read_entry(input int idx, input logic [BASE_W-1:0] exp, input string name);
        rd_idx = DL'(idx);
        tick();
        vectors++;
        if (rd_data[ENTRY_W-1 -: BASE_W] !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s idx %0d got %h expected %h", name, idx, rd_data[ENTRY_W-1 -: BASE_W], exp);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        vectors++;
        if (state !== 2'b00 || entry_cnt !== 7'd0 || drop_cnt !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state got state %b cnt %0d drop %0d expected 00 0 0", state, entry_cnt, drop_cnt);
        end
        vectors++;
        if (rd_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_rd_data got %h expected 0", rd_data);
        end
        vectors++;
        if (slave_id !== 8'd5) begin
            miscompares++;
            $display("[TB] FAIL slave_id got %0d expected 5", slave_id);
        end
        reset = 1'b0;
        tick();
        do_write(24'h000004, 32'h1111_1111, 4'hF);
        vectors++;
        if (state !== 2'b00 || entry_cnt !== 7'd0) begin
            miscompares++;
            $display("[TB] FAIL idle_no_capture got state %b cnt %0d expected 00 0", state, entry_cnt);
        end
    endtask

    task automatic test_single_write();
        pulse_arm();
        vectors++;
        if (state !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL arm_state got %b expected 01", state);
        end
        do_write(24'h000010, 32'hDEAD_BEEF, 4'hF);
        vectors++;
        if (entry_cnt !== 7'd1) begin
            miscompares++;
            $display("[TB] FAIL single_write_cnt got %0d expected 1", entry_cnt);
        end
        read_entry(0, make_entry(1'b1, 4'hF, 24'h000010, 32'hDEAD_BEEF), "single_write_entry");
    endtask

    task automatic test_read_latency();
        pulse_arm();
        RD = 1'b1; ADDR_RD = 24'h000020;
        tick();
        RD = 1'b0; DOUT = 32'h1234_5678;
        tick();
        DOUT = '0;
        vectors++;
        if (entry_cnt !== 7'd0) begin
            miscompares++;
            $display("[TB] FAIL read_not_yet got %0d expected 0", entry_cnt);
        end
        tick();
        vectors++;
        if (entry_cnt !== 7'd1) begin
            miscompares++;
            $display("[TB] FAIL read_stored got %0d expected 1", entry_cnt);
        end
        read_entry(0, make_entry(1'b0, 4'hF, 24'h000020, 32'h1234_5678), "read_entry");
    endtask

    task automatic test_wrap();
        pulse_arm();
        for (int i = 0; i < 70; i++) do_write(AB'(i), DB'(i), 4'hF);
        do_stop();
        vectors++;
        if (state !== 2'b11 || entry_cnt !== 7'd64 || drop_cnt !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL wrap_status got state %b cnt %0d drop %0d expected 11 64 0", state, entry_cnt, drop_cnt);
        end
        read_entry(0,  make_entry(1'b1, 4'hF, 24'd6,  32'd6),  "wrap_oldest");
        read_entry(1,  make_entry(1'b1, 4'hF, 24'd7,  32'd7),  "wrap_second");
        read_entry(63, make_entry(1'b1, 4'hF, 24'd69, 32'd69), "wrap_newest");
    endtask

    task automatic test_trigger();
        trig_addr = 24'h000100; trig_mask = 24'hFFFFFF; trig_wr = 1'b1; post_len = 6'd3;
        pulse_arm();
        do_write(24'h000200, 32'hA000_0000, 4'hF);
        do_write(24'h000101, 32'hA000_0001, 4'hF);
        vectors++;
        if (state !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL trig_no_match got %b expected 01", state);
        end
        do_write(24'h000100, 32'hB000_0000, 4'hF);
        vectors++;
        if (state !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL trig_enter_post got %b expected 10", state);
        end
        for (int k = 0; k < 5; k++) begin
            do_write(24'h000300 + AB'(4*k), 32'hC000_0000 + DB'(k), 4'hF);
            vectors++;
            if (state !== ((k >= 2) ? 2'b11 : 2'b10)) begin
                miscompares++;
                $display("[TB] FAIL trig_post_step%0d got %b expected %b", k, state, (k >= 2) ? 2'b11 : 2'b10);
            end
        end
        vectors++;
        if (entry_cnt !== 7'd6) begin
            miscompares++;
            $display("[TB] FAIL trig_cnt got %0d expected 6", entry_cnt);
        end
        read_entry(2, make_entry(1'b1, 4'hF, 24'h000100, 32'hB000_0000), "trig_entry");
        read_entry(5, make_entry(1'b1, 4'hF, 24'h000308, 32'hC000_0002), "trig_last");
        trig_wr = 1'b0; post_len = '0;
    endtask

    task automatic test_collision();
        logic [7:0] wr_v;
        logic [7:0] rd_v;
        logic [7:0] do_v;
        logic [AB-1:0] rd_a [8];
        logic [DB-1:0] do_d [8];
        logic [AB-1:0] wr_a [8];
        logic [DB-1:0] wr_d [8];
        logic [3:0]    wr_b [8];
        wr_v = 8'b0010_1100;
        rd_v = 8'b0000_1011;
        do_v = 8'b0001_0110;
        for (int c = 0; c < 8; c++) begin
            rd_a[c] = '0; do_d[c] = '0; wr_a[c] = '0; wr_d[c] = '0; wr_b[c] = '0;
        end
        rd_a[0] = 24'h40; rd_a[1] = 24'h44; rd_a[3] = 24'h48;
        do_d[1] = 32'hA1; do_d[2] = 32'hA2; do_d[4] = 32'hA3;
        wr_a[2] = 24'h50; wr_d[2] = 32'hB1; wr_b[2] = 4'h3;
        wr_a[3] = 24'h54; wr_d[3] = 32'hB2; wr_b[3] = 4'hC;
        wr_a[5] = 24'h58; wr_d[5] = 32'hB3; wr_b[5] = 4'hF;
        pulse_arm();
        for (int c = 0; c < 8; c++) begin
            WR = wr_v[c]; ADDR_WR = wr_a[c]; DIN = wr_d[c]; BSEL = wr_b[c];
            RD = rd_v[c]; ADDR_RD = rd_a[c];
            DOUT = do_v[c] ? do_d[c] : '0;
            tick();
        end
        WR = 1'b0; RD = 1'b0; DOUT = '0;
        do_stop();
        vectors++;
        if (drop_cnt !== 8'd1 || entry_cnt !== 7'd5) begin
            miscompares++;
            $display("[TB] FAIL collision_counts got drop %0d cnt %0d expected 1 5", drop_cnt, entry_cnt);
        end
        read_entry(0, make_entry(1'b1, 4'h3, 24'h50, 32'hB1), "collision_w1");
        read_entry(1, make_entry(1'b1, 4'hC, 24'h54, 32'hB2), "collision_w2");
        read_entry(2, make_entry(1'b0, 4'hF, 24'h40, 32'hA1), "collision_r1");
        read_entry(3, make_entry(1'b1, 4'hF, 24'h58, 32'hB3), "collision_w3");
        read_entry(4, make_entry(1'b0, 4'hF, 24'h48, 32'hA3), "collision_r3");
    endtask

    task automatic test_overrides();
        post_len = 6'd4;
        pulse_arm();
        stop = 1'b1; force_trig = 1'b1;
        tick();
        stop = 1'b0; force_trig = 1'b0;
        vectors++;
        if (state !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL stop_over_trig got %b expected 11", state);
        end
        arm = 1'b1; stop = 1'b1;
        tick();
        arm = 1'b0; stop = 1'b0;
        vectors++;
        if (state !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL arm_over_stop got %b expected 01", state);
        end
        post_len = 6'd0;
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        vectors++;
        if (state !== 2'b11 || entry_cnt !== 7'd0) begin
            miscompares++;
            $display("[TB] FAIL force_post0 got state %b cnt %0d expected 11 0", state, entry_cnt);
        end
    endtask

    task automatic test_reset_mid_post();
        trig_addr = 24'h000100; trig_mask = 24'hFFFFFF; trig_wr = 1'b1; post_len = 6'd5;
        pulse_arm();
        do_write(24'h000100, 32'h5555_0000, 4'hF);
        do_write(24'h000104, 32'h5555_0001, 4'hF);
        vectors++;
        if (state !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_post got %b expected 10", state);
        end
        rd_idx = 6'd0;
        tick();
        reset = 1'b1;
        #1;
        vectors++;
        if (state !== 2'b00 || entry_cnt !== 7'd0 || rd_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_post got state %b cnt %0d data %h expected 00 0 0", state, entry_cnt, rd_data);
        end
        tick();
        reset = 1'b0;
        trig_wr = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_latency();
        test_wrap();
        test_trigger();
        test_collision();
        test_overrides();
        test_reset_mid_post();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
